// File: rtl/mean_sq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mean_sq_pkg
//  Description : Shared widths and state encoding for the mean-square
//                accumulator (sample width, square width, result width,
//                ACCUM/HOLD state enum).
//  Revision    : 1.0 - initial release
// ============================================================================
package mean_sq_pkg;

    localparam int SAMPLE_W = 8;   // signed input sample width
    localparam int SQ_W     = 15;  // unsigned square width (max 16384 for -128)
    localparam int RESULT_W = 16;  // unsigned mean-square result width

    typedef enum logic [0:0] {
        ACCUM = 1'b0,   // taking samples: in_ready=1, out_valid=0
        HOLD  = 1'b1    // presenting result: in_ready=0, out_valid=1
    } state_e;

endpackage : mean_sq_pkg
`default_nettype wire

// File: rtl/mean_sq_acc.sv
`default_nettype none
// ============================================================================
//  Module      : mean_sq_acc
//  Description : Block mean-square accumulator. Squares 2^LOG2_N signed 8-bit
//                samples, sums them and presents sum >> LOG2_N as the x
//                operand of a downstream square-root stage.
//  Config      : MEAN_SQ_ROUND_EN - when defined, adds 2^(LOG2_N-1) before
//                the final shift (round half up); otherwise truncates.
//  Ports       : clk        - sole clock, rising edge
//                rst        - synchronous active-high reset
//                in_valid   - in_data carries a sample
//                in_ready   - a sample is accepted this cycle if in_valid
//                in_data    - signed 8-bit sample
//                out_valid  - out_data holds a fresh mean-square result
//                out_ready  - downstream takes out_data
//                out_data   - unsigned 16-bit mean square
//  Revision    : 1.0 - initial release
// ============================================================================
module mean_sq_acc
    import mean_sq_pkg::*;
#(
    parameter int LOG2_N = 4            // log2 of samples per block, 1..8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RESULT_W-1:0] out_data
);

    // Sum of 2^LOG2_N squares of at most 2^14 each never exceeds 2^(14+LOG2_N),
    // and the rounding constant keeps it below 2^(15+LOG2_N): no overflow.
    localparam int ACC_W = SQ_W + LOG2_N;

    state_e              r_state;
    logic [LOG2_N-1:0]   r_count;
    logic [ACC_W-1:0]    r_sum;
    logic [RESULT_W-1:0] r_out;

    logic signed [2*SAMPLE_W-1:0] w_prod;
    logic [ACC_W-1:0]             w_sum_next;
    logic [ACC_W-1:0]             w_total;
    logic                         w_accept;
    logic                         w_last;

    // Square is non-negative; zero-extension into the accumulator is exact.
    assign w_prod     = $signed(in_data) * $signed(in_data);
    assign w_sum_next = r_sum + ACC_W'($unsigned(w_prod));

`ifdef MEAN_SQ_ROUND_EN
    localparam logic [ACC_W-1:0] c_ROUND = ACC_W'(1) << (LOG2_N - 1);
    assign w_total = w_sum_next + c_ROUND;
`else
    assign w_total = w_sum_next;
`endif

    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == HOLD);
    assign out_data  = r_out;

    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_count == {LOG2_N{1'b1}});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUM;
            r_count <= '0;
            r_sum   <= '0;
            r_out   <= '0;
        end else begin
            case (r_state)
                ACCUM: begin
                    if (w_accept) begin
                        // Counter wraps to 0 on the final sample of a block.
                        r_count <= r_count + 1'b1;
                        if (w_last) begin
                            r_out   <= RESULT_W'(w_total >> LOG2_N);
                            r_sum   <= '0;
                            r_state <= HOLD;
                        end else begin
                            r_sum   <= w_sum_next;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state <= ACCUM;
                    end
                end
                default: r_state <= ACCUM;
            endcase
        end
    end

endmodule : mean_sq_acc
`default_nettype wire

// File: tb/tb_mean_sq_acc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mean_sq_acc
//  Description : Directed self-checking bench for mean_sq_acc (LOG2_N = 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mean_sq_acc;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;

    int n_checks;
    int n_fail;

    mean_sq_acc #(.LOG2_N(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer samples until n have been accepted; gaps randomise in_valid.
    task automatic push(input logic [7:0] d, input int n, input bit gaps);
        int acc;
        int guard;
        acc   = 0;
        guard = 0;
        while (acc < n && guard < 1000) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = d;
            if (in_valid && in_ready) acc++;
            tick();
            guard++;
        end
        in_valid = 1'b0;
        if (acc < n) check_eq("push_timeout", 32'(acc), 32'(n));
    endtask

    // Drain the held result and confirm return to ACCUM.
    task automatic release_result(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    logic [15:0] exp_round;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;
`ifdef MEAN_SQ_ROUND_EN
        exp_round = 16'd2;   // 25/16 = 1.5625 rounds up
`else
        exp_round = 16'd1;   // truncated
`endif
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check_eq("rst_in_ready",  32'(in_ready),  32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data",  32'(out_data),  32'd0);

        // 16 samples of 3 with out_ready high -> 9, one-cycle latency
        out_ready = 1'b1;
        push(8'd3, 15, 1'b0);
        check_eq("b3_not_yet_valid", 32'(out_valid), 32'd0);
        push(8'd3, 1, 1'b0);
        check_eq("b3_latency_valid", 32'(out_valid), 32'd1);
        check_eq("b3_data",          32'(out_data),  32'd9);
        tick();
        out_ready = 1'b0;
        check_eq("b3_back_accum",    32'(in_ready),  32'd1);
        check_eq("b3_data_retained", 32'(out_data),  32'd9);

        // 16 samples of -128 -> 16384, then held with out_ready low
        push(8'h80, 16, 1'b0);
        check_eq("max_valid", 32'(out_valid), 32'd1);
        check_eq("max_data",  32'(out_data),  32'd16384);
        in_valid = 1'b1;
        in_data  = 8'd77;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("hold_data",     32'(out_data),  32'd16384);
            check_eq("hold_in_ready", 32'(in_ready),  32'd0);
            check_eq("hold_valid",    32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        release_result("max_rel");

        // No samples counted during hold: block still needs a full 16
        push(8'd4, 15, 1'b0);
        check_eq("hold_nocount_15", 32'(out_valid), 32'd0);
        push(8'd4, 1, 1'b0);
        check_eq("hold_nocount_16", 32'(out_valid), 32'd1);
        check_eq("b4_data",         32'(out_data),  32'd16);
        release_result("b4_rel");

        // 15 zeros then 5 -> 25/16
        push(8'd0, 15, 1'b0);
        push(8'd5, 1, 1'b0);
        check_eq("round_valid", 32'(out_valid), 32'd1);
        check_eq("round_data",  32'(out_data),  32'(exp_round));
        release_result("round_rel");

        // Reset after 7 samples (with a handshake pending) discards the block
        push(8'd100, 7, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd100;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check_eq("mid_rst_in_ready",  32'(in_ready),  32'd1);
        check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_out_data",  32'(out_data),  32'd0);
        push(8'd2, 15, 1'b0);
        check_eq("post_rst_15", 32'(out_valid), 32'd0);
        push(8'd2, 1, 1'b0);
        check_eq("post_rst_valid", 32'(out_valid), 32'd1);
        check_eq("post_rst_data",  32'(out_data),  32'd4);
        release_result("post_rst_rel");

        // Random in_valid gaps over 16 accepts of 10 -> 100
        push(8'd10, 15, 1'b1);
        check_eq("gap_15", 32'(out_valid), 32'd0);
        push(8'd10, 1, 1'b1);
        check_eq("gap_valid", 32'(out_valid), 32'd1);
        check_eq("gap_data",  32'(out_data),  32'd100);
        release_result("gap_rel");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule : tb_mean_sq_acc
`default_nettype wire

// File: doc/mean_sq_acc.md
MEAN_SQ_ACC -- requirements
Module: mean_sq_acc

Interface
REQ-001 SHALL have parameter: LOG2_N, 4, log2 of samples per block (legal range 1..8).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  in_data carries a sample.
REQ-005 SHALL have port: in_ready  output  1  block accepts a sample this cycle.
REQ-006 SHALL have port: in_data  input  8  signed two's-complement sample.
REQ-007 SHALL have port: out_valid  output  1  out_data holds a mean-square result.
REQ-008 SHALL have port: out_ready  input  1  downstream square-root stage takes out_data.
REQ-009 SHALL have port: out_data  output  16  unsigned mean square, the x operand of the square-root stage.

Function
REQ-010 SHALL accept a sample only on a cycle where in_valid && in_ready.
REQ-011 SHALL square each accepted sample as signed*signed, giving a 15-bit unsigned value (max 16384 for -128).
REQ-012 SHALL accumulate squares in an unsigned register of 15+LOG2_N bits; overflow impossible by construction.
REQ-013 SHALL count accepted samples in a LOG2_N-bit counter, wrapping to 0 on the 2^LOG2_N-th accept.
REQ-014 SHALL implement two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-015 SHALL on the 2^LOG2_N-th accept in ACCUM register out_data = (sum + square of that sample) >> LOG2_N, clear sum, and enter HOLD next cycle.
REQ-016 SHALL have latency of exactly one cycle: out_valid high in the cycle after the final sample's accept.
REQ-017 SHALL in HOLD keep out_data stable and ignore in_valid/in_data until out_valid && out_ready.
REQ-018 SHALL on out_valid && out_ready return to ACCUM next cycle; earliest next-block accept is that cycle.
REQ-019 SHALL keep out_data unchanged in ACCUM (last result retained) and never modify it except per REQ-015.
REQ-020 SHALL produce in_ready and out_valid as pure decodes of the state register (no combinational path from inputs).

Reset
REQ-021 SHALL on rst force state=ACCUM, count=0, sum=0, out_data=0, hence in_ready=1, out_valid=0 next cycle.
REQ-022 SHALL give rst priority over every handshake in the same cycle; a partial block in progress is discarded.

Configuration
REQ-023 SHALL honour macro MEAN_SQ_ROUND_EN: when defined, REQ-015 adds 2^(LOG2_N-1) before the shift (round half up).
REQ-024 SHALL without MEAN_SQ_ROUND_EN truncate (plain shift); result width and timing identical in both builds.

Structure
REQ-025 SHALL place the state enum (ACCUM, HOLD), sample width 8 and result width 16 in shared package mean_sq_pkg.
REQ-026 SHALL be a single module with no sub-module; squaring is inline.

Verification
REQ-027 SHALL cover: LOG2_N=4, 16 samples of 3, out_ready=1 -> out_valid one cycle after 16th accept, out_data=9.
REQ-028 SHALL cover: 16 samples of -128 -> out_data=16384 (maximum, no overflow).
REQ-029 SHALL cover: 15 samples of 0 then 5 -> out_data=1 without MEAN_SQ_ROUND_EN, 2 with it.
REQ-030 SHALL cover: result ready, out_ready low 5 cycles while in_valid=1 -> out_data stable, in_ready=0, no samples counted.
REQ-031 SHALL cover: rst after 7 accepted samples, then 16 samples of 2 -> out_data=4 (partial block discarded).
REQ-032 SHALL cover: in_valid toggling randomly 50% over 16 accepts of value 10 -> out_data=100, exactly 16 accepts counted.
